mempool_tile_resp_age_arbiter: RTL and testbench
================================================

# mempool_tile_resp_age_arbiter

Parametrised N-to-M response arbiter for the MemPool tile response path. It forwards up to NumOut input responses per cycle, always granting the oldest waiting responses first by per-input saturating age counters. New (age 0) requests are capped per cycle, ties are broken round-robin, and a stalled output is locked to its input until the handshake completes. It sits between the tile's bank/remote response sources and the core response ports.

## Interface
- NumInp, 16, number of response inputs (≥2)
- NumOut, 3, number of output ports (1..NumInp)
- MaxNew, 2, max age-0 inputs granted per cycle (1..NumOut)
- AgeWidth, 4, width of per-input age counter
- payload_t, logic, response payload type
- clk_i  in  1  clock
- rst_ni  in  1  reset. Asynchronous, active-low. One clock domain.
- data_i  in  NumInp×payload_t  input payloads
- valid_i  in  NumInp  input valids
- ready_o  out  NumInp  input readies. Combinational from valid_i, state and ready_i.
- data_o  out  NumOut×payload_t  output payloads
- valid_o  out  NumOut  output valids. Never depend combinationally on ready_i.
- ready_i  in  NumOut  output readies

## Operation
- Inputs and outputs follow the stream protocol.
  - Once valid_i[i] is high, it and data_i[i] are held until the handshake.
  - Violation: assertion, not handled.
- Age counter age_q[i]:
  - Cleared on handshake or when !valid_i[i].
  - Otherwise incremented when valid_i[i] & !ready_o[i].
  - Saturates at 2^AgeWidth−1.
- Per-output lock FSM, states FREE and LOCKED (lock_idx_q[k]):
  - FREE→LOCKED when valid_o[k] & !ready_i[k]; captures the assigned input index.
  - LOCKED→FREE on ready_i[k].
  - A LOCKED output keeps its input, and that input is excluded from fresh selection.
- Fresh selection, over valid unlocked inputs, fills FREE outputs in ascending k:
  - Priority order is age descending.
  - Equal ages are ordered by index rotated from rr_q (rr_q first).
  - At most MaxNew age-0 inputs are selected; the remaining age-0 inputs wait.
  - Each input is granted to at most one output.
- Output k:
  - valid_o[k] = assigned; data_o[k] = data_i[assigned idx].
  - ready_o[i] = ready_i[k] of the output i is assigned to, else 0.
- rr_q advances by 1 mod NumInp in every cycle with at least one output handshake.

## Timing
- Without the output register, input-to-output latency is 0 cycles.
  - A request with a ready output and within priority is accepted in its first valid cycle.
- Reset values:
  - age_q = 0, lock FSMs FREE, rr_q = 0.
  - valid_o = 0 while rst_ni low.
  - ready_o = 0 while rst_ni low.
- Reset asserted mid-stall discards all locks; no output is held across reset.
- Simultaneous handshake and age saturation: handshake wins, age → 0.
- Output k has ready_i high in the same cycle it locks: no lock is taken; the handshake completes.
- All inputs valid and all outputs stalled: locks hold, ages of the others saturate, no wrap.

## Configuration
- MEMPOOL_RESP_ARB_OUT_REG_EN defined: each output gets a one-entry stream register.
  - Latency is 1 cycle.
  - Lock FSMs operate on the register input side.
  - Register ready = empty | ready_i[k], giving full throughput.
  - valid_o resets to 0.
- Undefined: purely combinational forward path as above.

## Structure
- Package mempool_resp_arb_pkg holds the lock state enum (FREE, LOCKED) and the function for saturating age increment.
- Age and index widths are derived locally from parameters.
- Sub-module mempool_resp_age_rank:
  - Inputs: valid mask, ages, rr_q, MaxNew.
  - Output: ordered list of up to NumOut selected indices with valids.
  - Purely combinational.

## Test plan
- NumInp=16, NumOut=3, inputs 2, 5, 9 valid at age 0, MaxNew=2, all ready_i=1:
  - Inputs 2 and 5 granted to outputs 0 and 1.
  - Input 9 waits, age 1 next cycle, then granted first.
- Inputs 4 (age 3) and 1 (age 1) valid, NumOut=1: input 4 granted before input 1.
- Output 0 stalled 5 cycles while input 7 is locked:
  - valid_o[0] and data_o[0] remain stable.
  - Another valid input is routed to output 1.
  - Input 7 handshakes on cycle 6.
- All 16 inputs valid, ready_i=0 for 20 cycles with AgeWidth=4:
  - Ages saturate at 15, no wrap.
  - After ready_i=1, the 3 lowest rotated indices from rr_q drain first.
- Reset asserted while output 2 is LOCKED:
  - valid_o=0, lock cleared, ages 0.
  - The next grant follows the age-0/rr rules.
- With MEMPOOL_RESP_ARB_OUT_REG_EN: single request appears on data_o one cycle after valid_i; back-to-back requests sustain 1/cycle per output.

Source files
------------

// File: rtl/mempool_resp_arb_pkg.sv
// Shared types and helpers for the MemPool tile response age arbiter.
// Lock-state enum and saturating age increment (ages up to 16 bits wide).
package mempool_resp_arb_pkg;

  typedef enum logic {
    FREE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

  function automatic logic [15:0] sat_inc(
    input logic [15:0] a,
    input int unsigned w
  );
    logic [15:0] max;
    max = 16'((32'd1 << w) - 32'd1);
    return (a == max) ? a : a + 16'd1;
  endfunction

endpackage

// File: rtl/mempool_resp_age_rank.sv
// Combinational ranking: picks up to NumOut inputs, oldest first,
// ties in round-robin order from rr, at most MaxNew age-0 picks.
module mempool_resp_age_rank #(
  parameter int unsigned NumInp   = 16,
  parameter int unsigned NumOut   = 3,
  parameter int unsigned MaxNew   = 2,
  parameter int unsigned AgeWidth = 4,
  localparam int unsigned IdxW    = $clog2(NumInp)
) (
  input  logic [NumInp-1:0]               valid,
  input  logic [NumInp-1:0][AgeWidth-1:0] age,
  input  logic [IdxW-1:0]                 rr,
  output logic [NumOut-1:0][IdxW-1:0]     sel_idx,
  output logic [NumOut-1:0]               sel_vld
);

  always_comb begin
    logic [NumInp-1:0]   taken;
    logic [AgeWidth-1:0] best_age;
    logic [IdxW-1:0]     best;
    logic [IdxW-1:0]     cand;
    logic                found;
    int unsigned         n_new;
    taken    = '0;
    best_age = '0;
    best     = '0;
    cand     = '0;
    found    = 1'b0;
    n_new    = 0;
    sel_idx  = '0;
    sel_vld  = '0;
    for (int unsigned k = 0; k < NumOut; k++) begin
      found    = 1'b0;
      best     = '0;
      best_age = '0;
      // Scan in rotated order; strict '>' keeps the earliest on ties.
      for (int unsigned j = 0; j < NumInp; j++) begin
        cand = IdxW'((32'(rr) + j) % NumInp);
        if (valid[cand] && !taken[cand] &&
            (age[cand] != '0 || n_new < MaxNew) &&
            (!found || age[cand] > best_age)) begin
          found    = 1'b1;
          best     = cand;
          best_age = age[cand];
        end
      end
      if (found) begin
        taken[best] = 1'b1;
        sel_idx[k]  = best;
        sel_vld[k]  = 1'b1;
        if (best_age == '0) n_new++;
      end
    end
  end

endmodule

// File: rtl/mempool_tile_resp_age_arbiter.sv
// N-to-M age-ordered response arbiter with per-output stall locks.
// MEMPOOL_RESP_ARB_OUT_REG_EN adds a one-entry register per output.
module mempool_tile_resp_age_arbiter
  import mempool_resp_arb_pkg::*;
#(
  parameter int unsigned NumInp   = 16,
  parameter int unsigned NumOut   = 3,
  parameter int unsigned MaxNew   = 2,
  parameter int unsigned AgeWidth = 4,
  parameter type         payload_t = logic
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  payload_t [NumInp-1:0]    data_i,
  input  logic     [NumInp-1:0]    valid_i,
  output logic     [NumInp-1:0]    ready_o,
  output payload_t [NumOut-1:0]    data_o,
  output logic     [NumOut-1:0]    valid_o,
  input  logic     [NumOut-1:0]    ready_i
);

  localparam int unsigned IdxW = $clog2(NumInp);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumInp - 1);

  lock_state_e                     lock_q [NumOut];
  lock_state_e                     lock_d [NumOut];
  logic [NumOut-1:0][IdxW-1:0]     lock_idx_q, lock_idx_d;
  logic [NumInp-1:0][AgeWidth-1:0] age_q, age_d;
  logic [IdxW-1:0]                 rr_q, rr_d;
  logic [NumInp-1:0]               locked_in, eligible;
  logic [NumOut-1:0][IdxW-1:0]     sel_idx, asg_idx;
  logic [NumOut-1:0]               sel_vld, asg_vld;
  logic [NumOut-1:0]               out_ready, hs;

  always_comb begin
    locked_in = '0;
    for (int unsigned k = 0; k < NumOut; k++) begin
      if (lock_q[k] == LOCKED) locked_in[lock_idx_q[k]] = 1'b1;
    end
  end

  assign eligible = valid_i & ~locked_in;

  mempool_resp_age_rank #(
    .NumInp   (NumInp),
    .NumOut   (NumOut),
    .MaxNew   (MaxNew),
    .AgeWidth (AgeWidth)
  ) i_rank (
    .valid   (eligible),
    .age     (age_q),
    .rr      (rr_q),
    .sel_idx (sel_idx),
    .sel_vld (sel_vld)
  );

  // Locked outputs keep their input; free outputs take ranked picks in order.
  always_comb begin
    int unsigned p;
    p       = 0;
    asg_idx = '0;
    asg_vld = '0;
    for (int unsigned k = 0; k < NumOut; k++) begin
      if (lock_q[k] == LOCKED) begin
        asg_idx[k] = lock_idx_q[k];
        asg_vld[k] = valid_i[lock_idx_q[k]];
      end else begin
        for (int unsigned n = 0; n < NumOut; n++) begin
          if (n == p) begin
            asg_idx[k] = sel_idx[n];
            asg_vld[k] = sel_vld[n];
          end
        end
        p++;
      end
    end
  end

`ifdef MEMPOOL_RESP_ARB_OUT_REG_EN
  logic     [NumOut-1:0] reg_vld_q;
  payload_t [NumOut-1:0] reg_data_q;

  assign out_ready = ~reg_vld_q | ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reg_vld_q  <= '0;
      reg_data_q <= '0;
    end else begin
      for (int unsigned k = 0; k < NumOut; k++) begin
        if (out_ready[k]) begin
          reg_vld_q[k]  <= asg_vld[k];
          reg_data_q[k] <= data_i[asg_idx[k]];
        end
      end
    end
  end

  assign valid_o = reg_vld_q;
  assign data_o  = reg_data_q;
`else
  assign out_ready = ready_i;
  assign valid_o   = asg_vld & {NumOut{rst_ni}};

  always_comb begin
    data_o = '0;
    for (int unsigned k = 0; k < NumOut; k++) begin
      data_o[k] = data_i[asg_idx[k]];
    end
  end
`endif

  assign hs = asg_vld & out_ready;

  always_comb begin
    ready_o = '0;
    for (int unsigned k = 0; k < NumOut; k++) begin
      if (hs[k]) ready_o[asg_idx[k]] = 1'b1;
    end
    ready_o &= {NumInp{rst_ni}};
  end

  always_comb begin
    for (int unsigned k = 0; k < NumOut; k++) begin
      lock_d[k]     = lock_q[k];
      lock_idx_d[k] = lock_idx_q[k];
      unique case (lock_q[k])
        FREE: begin
          if (asg_vld[k] && !out_ready[k]) begin
            lock_d[k]     = LOCKED;
            lock_idx_d[k] = asg_idx[k];
          end
        end
        LOCKED: begin
          if (out_ready[k]) lock_d[k] = FREE;
        end
        default: lock_d[k] = FREE;
      endcase
    end
  end

  always_comb begin
    age_d = '0;
    for (int unsigned i = 0; i < NumInp; i++) begin
      if (!valid_i[i] || ready_o[i]) begin
        age_d[i] = '0;
      end else begin
        age_d[i] = AgeWidth'(sat_inc(16'(age_q[i]), AgeWidth));
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (|hs) rr_d = (rr_q == LastIdx) ? '0 : rr_q + IdxW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned k = 0; k < NumOut; k++) lock_q[k] <= FREE;
      lock_idx_q <= '0;
      age_q      <= '0;
      rr_q       <= '0;
    end else begin
      for (int unsigned k = 0; k < NumOut; k++) lock_q[k] <= lock_d[k];
      lock_idx_q <= lock_idx_d;
      age_q      <= age_d;
      rr_q       <= rr_d;
    end
  end

  for (genvar i = 0; i < NumInp; i++) begin : g_stream_chk
    assert property (@(posedge clk_i) disable iff (!rst_ni)
      valid_i[i] && !ready_o[i] |=> valid_i[i] && $stable(data_i[i]));
  end

endmodule

// File: tb/tb_mempool_tile_resp_age_arbiter.sv
// Randomized bench for the response age arbiter against a
// sort-based priority model.
module tb_mempool_tile_resp_age_arbiter;

  localparam int NI   = 16;
  localparam int NO   = 3;
  localparam int MN   = 2;
  localparam int AW   = 4;
  localparam int AMAX = (1 << AW) - 1;

  typedef logic [7:0] pl_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  pl_t  [NI-1:0]      data_i;
  logic [NI-1:0]      valid_i;
  logic [NI-1:0]      ready_o;
  pl_t  [NO-1:0]      data_o;
  logic [NO-1:0]      valid_o;
  logic [NO-1:0]      ready_i;

  mempool_tile_resp_age_arbiter #(
    .NumInp    (NI),
    .NumOut    (NO),
    .MaxNew    (MN),
    .AgeWidth  (AW),
    .payload_t (pl_t)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .data_i  (data_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .valid_o (valid_o),
    .ready_i (ready_i)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  int           age  [NI];
  int           lock [NO];
  int           rr;
  logic [NO-1:0] e_vld;
  int           e_idx [NO];
  logic [NI-1:0] e_rdy;

  function automatic void model_reset();
    for (int i = 0; i < NI; i++) age[i] = 0;
    for (int k = 0; k < NO; k++) lock[k] = -1;
    rr = 0;
    e_rdy = '0;
  endfunction

  function automatic bit is_locked(int i);
    for (int k = 0; k < NO; k++) if (lock[k] == i) return 1'b1;
    return 1'b0;
  endfunction

  // Priority key: age major, distance from rr minor (closer is better).
  function automatic void predict();
    int q[$];
    int pick[$];
    int nnew, p, a, idx;
    nnew = 0;
    p    = 0;
    for (int i = 0; i < NI; i++) begin
      if (valid_i[i] && !is_locked(i))
        q.push_back(age[i] * NI + (NI - 1 - ((i - rr + NI) % NI)));
    end
    q.rsort();
    foreach (q[j]) begin
      a   = q[j] / NI;
      idx = (rr + NI - 1 - (q[j] % NI)) % NI;
      if (pick.size() < NO && (a > 0 || nnew < MN)) begin
        pick.push_back(idx);
        if (a == 0) nnew++;
      end
    end
    for (int k = 0; k < NO; k++) begin
      e_vld[k] = 1'b0;
      e_idx[k] = 0;
      if (lock[k] >= 0) begin
        e_vld[k] = 1'b1;
        e_idx[k] = lock[k];
      end else if (p < pick.size()) begin
        e_vld[k] = 1'b1;
        e_idx[k] = pick[p];
        p++;
      end
    end
    e_rdy = '0;
    for (int k = 0; k < NO; k++)
      if (e_vld[k] && ready_i[k]) e_rdy[e_idx[k]] = 1'b1;
  endfunction

  function automatic void advance();
    bit any_hs;
    any_hs = 1'b0;
    for (int k = 0; k < NO; k++) if (e_vld[k] && ready_i[k]) any_hs = 1'b1;
    for (int i = 0; i < NI; i++) begin
      if (!valid_i[i] || e_rdy[i]) age[i] = 0;
      else if (age[i] < AMAX) age[i]++;
    end
    for (int k = 0; k < NO; k++) begin
      if (lock[k] >= 0) begin
        if (ready_i[k]) lock[k] = -1;
      end else if (e_vld[k] && !ready_i[k]) begin
        lock[k] = e_idx[k];
      end
    end
    if (any_hs) rr = (rr + 1) % NI;
  endfunction

  task automatic compare();
    pl_t [NO-1:0] exp_d, got_d;
    predict();
    for (int k = 0; k < NO; k++) begin
      exp_d[k] = e_vld[k] ? data_i[e_idx[k]] : 8'h00;
      got_d[k] = e_vld[k] ? data_o[k] : 8'h00;
    end
    check("valid_o", 128'(valid_o), 128'(e_vld));
    check("ready_o", 128'(ready_o), 128'(e_rdy));
    check("data_o", 128'(got_d), 128'(exp_d));
  endtask

  // Entered at posedge+1; leaves at the next posedge+1.
  task automatic step(input logic [NI-1:0] add, input logic [NO-1:0] rdy);
    for (int i = 0; i < NI; i++) begin
      if (add[i] && !valid_i[i]) begin
        valid_i[i] = 1'b1;
        data_i[i]  = pl_t'($urandom);
      end
    end
    ready_i = rdy;
    @(negedge clk);
    compare();
    advance();
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) if (e_rdy[i]) valid_i[i] = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    rst_n   = 1'b0;
    ready_i = NO'($urandom);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      check("rst_valid_o", 128'(valid_o), 128'(0));
      check("rst_ready_o", 128'(ready_o), 128'(0));
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  function automatic logic [NI-1:0] rand_mask(int pct);
    logic [NI-1:0] m;
    for (int i = 0; i < NI; i++) m[i] = ($urandom_range(99) < pct);
    return m;
  endfunction

  function automatic logic [NO-1:0] rand_rdy(int pct);
    logic [NO-1:0] m;
    for (int k = 0; k < NO; k++) m[k] = ($urandom_range(99) < pct);
    return m;
  endfunction

  initial begin
    model_reset();
    valid_i = '0;
    data_i  = '0;
    ready_i = '1;
    #1;
    for (int i = 0; i < NI; i++) data_i[i] = pl_t'($urandom);
    valid_i = NI'($urandom);
    @(posedge clk);
    #1;
    do_reset(2);

    // Drain leftovers, then three fresh requests with a cap of two.
    repeat (12) step('0, '1);
    step(NI'(1 << 2) | NI'(1 << 5) | NI'(1 << 9), '1);
    step('0, '1);
    step('0, '1);

    // Older input beats younger on a single ready output.
    step(NI'(1 << 4), 3'b000);
    step('0, 3'b000);
    step(NI'(1 << 1), 3'b000);
    repeat (4) step('0, 3'b001);
    repeat (4) step('0, '1);

    // Output 0 stalled with one input locked while others flow.
    step(NI'(1 << 7), 3'b110);
    repeat (5) step(NI'(1 << 3) | NI'(1 << 11), 3'b110);
    repeat (4) step('0, '1);

    // Full stall long enough to saturate every age, then drain.
    repeat (20) step('1, '0);
    repeat (10) step('0, '1);

    // Reset while output 2 holds a lock.
    step('1, 3'b011);
    step('0, 3'b011);
    do_reset(2);
    repeat (10) step('0, '1);

    // Random traffic with varying load and backpressure.
    for (int c = 0; c < 400; c++) begin
      step(rand_mask((c % 4) * 15 + 5), rand_rdy((c % 3) * 30 + 20));
      if (c == 250) do_reset(1);
    end
    repeat (10) step('0, '1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
